fifo_rd_skid: RTL and testbench

- Read-side drain stage that sits directly downstream of FIFO_top, in the r_clk domain.
- Pops words from the FIFO's r_empty/r_inc/r_data interface into a 2-entry skid buffer.
- Presents the words on a valid/ready stream (m_*).
- No combinational path from m_ready to r_inc, so consumer backpressure never lengthens the FIFO read path. Also counts delivered words.

---
 rtl/fifo_rd_skid.sv | 104 ++++++++++
 tb/tb_fifo_rd_skid.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Brief    : Drains a FIFO read port into a 2-entry skid buffer and presents it
//            as a valid/ready stream. The buffer also counts delivered words.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_reset,
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_inc,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    logic [CNT_WIDTH-1:0]  r_xfer;
    logic                  w_pop;
    logic                  w_drain;

    // Pop decision uses only registered state, so m_ready never reaches r_inc.
    assign w_pop   = ~r_reset & ~r_empty & (r_state != ST_TWO) & ~flush;
    assign w_drain = (r_state != ST_EMPTY) & m_ready;

    assign r_inc      = w_pop;
    assign m_valid    = (r_state != ST_EMPTY);
    assign m_data     = r_head;
    assign occupancy  = r_state;
    assign xfer_count = r_xfer;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_pop) begin
                        w_head_nxt  = r_data;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_drain) begin
                        w_head_nxt = r_data;
                    end else if (w_pop) begin
                        w_tail_nxt  = r_data;
                        w_state_nxt = ST_TWO;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_head_nxt  = r_tail;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_xfer  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            // A drain coincident with flush still counts as delivered.
            if (w_drain) begin
                r_xfer <= r_xfer + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_skid
// Brief    : Directed self-checking bench for fifo_rd_skid with a simple FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_skid;

    localparam int DW = 4;
    localparam int CW = 4;

    logic          r_clk = 1'b0;
    logic          r_reset;
    logic          r_empty;
    logic [DW-1:0] r_data;
    logic          r_inc;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          flush;
    logic [1:0]    occupancy;
    logic [CW-1:0] xfer_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    always #5 r_clk = ~r_clk;

    assign r_empty = (rd_ptr == wr_ptr);
    assign r_data  = mem[rd_ptr % 64];

    always @(posedge r_clk) begin
        if (r_inc) rd_ptr <= rd_ptr + 1;
    end

    fifo_rd_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .r_clk      (r_clk),
        .r_reset    (r_reset),
        .r_empty    (r_empty),
        .r_data     (r_data),
        .r_inc      (r_inc),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .flush      (flush),
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic test_reset();
        r_reset = 1'b1; m_ready = 1'b1; flush = 1'b0;
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        #7;
        checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL reset_r_inc got %0b want 0", r_inc); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if (m_data !== 4'd0) begin errors++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL reset_xfer got %0d want 0", xfer_count); end
        tick();
        r_reset = 1'b0;
        #1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            checks++; if (r_inc !== 1'b1) begin errors++; $display("FAIL stream_r_inc[%0d] got %0b want 1", i, r_inc); end
            if (i > 0) begin
                checks++; if (m_valid !== 1'b1 || m_data !== 4'(i)) begin errors++; $display("FAIL stream_data[%0d] got v%0b d%0d want v1 d%0d", i, m_valid, m_data, i); end
            end
            tick();
        end
        checks++; if (m_data !== 4'd4 || r_inc !== 1'b0) begin errors++; $display("FAIL stream_last got d%0d inc%0b want d4 inc0", m_data, r_inc); end
        tick();
        checks++; if (occupancy !== 2'd0 || xfer_count !== 4'd4) begin errors++; $display("FAIL stream_end got occ%0d xfer%0d want occ0 xfer4", occupancy, xfer_count); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        push(4'd5); push(4'd6); push(4'd7);
        #1;
        tick(); tick();
        checks++; if (occupancy !== 2'd2 || r_inc !== 1'b0) begin errors++; $display("FAIL bp_fill got occ%0d inc%0b want occ2 inc0", occupancy, r_inc); end
        checks++; if (m_data !== 4'd5 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got d%0d v%0b want d5 v1", m_data, m_valid); end
        tick();
        checks++; if (m_data !== 4'd5 || m_valid !== 1'b1 || occupancy !== 2'd2) begin errors++; $display("FAIL bp_stable got d%0d v%0b occ%0d want d5 v1 occ2", m_data, m_valid, occupancy); end
        m_ready = 1'b1;
        #1;
        for (int i = 5; i <= 7; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 4'(i)) begin errors++; $display("FAIL bp_order got v%0b d%0d want v1 d%0d", m_valid, m_data, i); end
            tick();
        end
        checks++; if (occupancy !== 2'd0 || xfer_count !== 4'd7) begin errors++; $display("FAIL bp_end got occ%0d xfer%0d want occ0 xfer7", occupancy, xfer_count); end
    endtask

    task automatic test_pop_drain();
        m_ready = 1'b0;
        push(4'd9);
        tick();
        checks++; if (occupancy !== 2'd1 || m_data !== 4'd9) begin errors++; $display("FAIL pd_setup got occ%0d d%0d want occ1 d9", occupancy, m_data); end
        push(4'hA);
        m_ready = 1'b1;
        #1;
        checks++; if (r_inc !== 1'b1) begin errors++; $display("FAIL pd_r_inc got %0b want 1", r_inc); end
        tick();
        checks++; if (occupancy !== 2'd1 || m_data !== 4'hA || xfer_count !== 4'd8) begin errors++; $display("FAIL pd_result got occ%0d d%0h xfer%0d want occ1 dA xfer8", occupancy, m_data, xfer_count); end
        tick();
        checks++; if (occupancy !== 2'd0 || xfer_count !== 4'd9) begin errors++; $display("FAIL pd_drain got occ%0d xfer%0d want occ0 xfer9", occupancy, xfer_count); end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        push(4'd3); push(4'd4);
        #1;
        tick(); tick();
        checks++; if (occupancy !== 2'd2 || m_data !== 4'd3) begin errors++; $display("FAIL fl_setup got occ%0d d%0d want occ2 d3", occupancy, m_data); end
        push(4'd5);
        flush = 1'b1; m_ready = 1'b1;
        #1;
        checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL fl_r_inc got %0b want 0", r_inc); end
        tick();
        checks++; if (occupancy !== 2'd0 || m_valid !== 1'b0 || xfer_count !== 4'd10) begin errors++; $display("FAIL fl_result got occ%0d v%0b xfer%0d want occ0 v0 xfer10", occupancy, m_valid, xfer_count); end
        checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL fl_gate_pop got %0b want 0", r_inc); end
        tick();
        checks++; if (occupancy !== 2'd0 || xfer_count !== 4'd10) begin errors++; $display("FAIL fl_hold got occ%0d xfer%0d want occ0 xfer10", occupancy, xfer_count); end
        flush = 1'b0;
        #1;
        checks++; if (r_inc !== 1'b1) begin errors++; $display("FAIL fl_resume_inc got %0b want 1", r_inc); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 4'd5) begin errors++; $display("FAIL fl_next got v%0b d%0d want v1 d5", m_valid, m_data); end
        tick();
        checks++; if (occupancy !== 2'd0 || xfer_count !== 4'd11) begin errors++; $display("FAIL fl_next_done got occ%0d xfer%0d want occ0 xfer11", occupancy, xfer_count); end
    endtask

    task automatic test_wrap();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(4'(i));
        #1;
        tick();
        for (int i = 0; i < 17; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 4'(i)) begin errors++; $display("FAIL wrap_data[%0d] got v%0b d%0d want v1 d%0d", i, m_valid, m_data, i & 15); end
            tick();
        end
        checks++; if (xfer_count !== 4'd12 || occupancy !== 2'd0) begin errors++; $display("FAIL wrap_count got xfer%0d occ%0d want xfer12 occ0", xfer_count, occupancy); end
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        push(4'd1); push(4'd2); push(4'd3);
        #1;
        tick(); tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_setup got occ%0d want occ2", occupancy); end
        #2;
        r_reset = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0 || xfer_count !== 4'd0 || m_data !== 4'd0) begin errors++; $display("FAIL ar_immediate got v%0b occ%0d xfer%0d d%0d want v0 occ0 xfer0 d0", m_valid, occupancy, xfer_count, m_data); end
        checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL ar_r_inc got %0b want 0", r_inc); end
        tick();
        checks++; if (r_inc !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL ar_held got inc%0b occ%0d want inc0 occ0", r_inc, occupancy); end
        r_reset = 1'b0;
        #1;
        checks++; if (r_inc !== 1'b1) begin errors++; $display("FAIL ar_release got %0b want 1", r_inc); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 4'd3) begin errors++; $display("FAIL ar_resume got v%0b d%0d want v1 d3", m_valid, m_data); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_pop_drain();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
